// File: rtl/muldiv_seq.sv
// Sequential RV32M multiply/divide unit: radix-2 shift-add multiply and restoring divide, one bit per cycle.
// Optional macro RV32_MULDIV_EARLY_OUT_EN: divide-by-zero and signed-overflow divides skip straight to DONE.
`timescale 1ns/1ps
module muldiv_seq (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        valid_i,
    output logic        ready_o,
    input  logic [2:0]  op_i,
    input  logic [31:0] operand_a_i,
    input  logic [31:0] operand_b_i,
    input  logic        flush_i,
    output logic        valid_o,
    input  logic        ready_i,
    output logic [31:0] result_o
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] FIX  = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    localparam logic [2:0] OP_MUL    = 3'd0;
    localparam logic [2:0] OP_MULH   = 3'd1;
    localparam logic [2:0] OP_MULHSU = 3'd2;
    localparam logic [2:0] OP_MULHU  = 3'd3;
    localparam logic [2:0] OP_DIV    = 3'd4;
    localparam logic [2:0] OP_DIVU   = 3'd5;
    localparam logic [2:0] OP_REM    = 3'd6;

    logic [1:0]  state_reg;
    logic [4:0]  count_reg;
    logic        init_reg;
    logic [2:0]  op_reg;
    logic [31:0] a_reg;
    logic [31:0] b_reg;
    logic [31:0] hi_reg;
    logic [31:0] lo_reg;
    logic [31:0] opnd_reg;
    logic [31:0] result_reg;

    logic        accept;
    logic        is_div;
    logic        neg_a;
    logic        neg_b;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic [32:0] add_sum;
    logic [32:0] shifted;
    logic        sub_ok;
    logic [31:0] sub_diff;
    logic [63:0] product;
    logic [63:0] prod_fixed;
    logic [31:0] quo_fixed;
    logic [31:0] rem_fixed;
    logic [31:0] fix_result;
    logic        early_hit;
    logic [31:0] early_result;

    assign ready_o  = (state_reg == IDLE);
    assign valid_o  = (state_reg == DONE);
    assign result_o = valid_o ? result_reg : 32'd0;
    assign accept   = valid_i && ready_o && !flush_i;

    assign is_div = op_reg[2];
    assign neg_a  = a_reg[31] && (op_reg == OP_MULH || op_reg == OP_MULHSU ||
                                  op_reg == OP_DIV  || op_reg == OP_REM);
    assign neg_b  = b_reg[31] && (op_reg == OP_MULH || op_reg == OP_DIV || op_reg == OP_REM);
    assign a_mag  = neg_a ? (~a_reg + 32'd1) : a_reg;
    assign b_mag  = neg_b ? (~b_reg + 32'd1) : b_reg;

    // Multiply keeps {partial product, multiplier} in hi/lo; divide keeps {remainder, dividend/quotient}.
    assign add_sum  = {1'b0, hi_reg} + (lo_reg[0] ? {1'b0, opnd_reg} : 33'd0);
    assign shifted  = {hi_reg, lo_reg[31]};
    assign sub_ok   = (shifted >= {1'b0, opnd_reg});
    assign sub_diff = shifted[31:0] - opnd_reg;

    assign product    = {hi_reg, lo_reg};
    assign prod_fixed = (neg_a ^ neg_b) ? (~product + 64'd1) : product;
    assign quo_fixed  = (neg_a ^ neg_b) ? (~lo_reg + 32'd1) : lo_reg;
    assign rem_fixed  = neg_a ? (~hi_reg + 32'd1) : hi_reg;

    always_comb begin
        fix_result = 32'd0;
        case (op_reg)
            OP_MUL:                      fix_result = prod_fixed[31:0];
            OP_MULH, OP_MULHSU, OP_MULHU: fix_result = prod_fixed[63:32];
            OP_DIV, OP_DIVU:             fix_result = (b_reg == 32'd0) ? 32'hFFFF_FFFF : quo_fixed;
            default:                     fix_result = (b_reg == 32'd0) ? a_reg : rem_fixed;
        endcase
    end

`ifdef RV32_MULDIV_EARLY_OUT_EN
    // Bit 0 of a divide op code is clear only for the signed variants (DIV, REM).
    assign early_hit = op_i[2] && ((operand_b_i == 32'd0) ||
                       (!op_i[0] && operand_a_i == 32'h8000_0000 && operand_b_i == 32'hFFFF_FFFF));
    assign early_result = (operand_b_i == 32'd0) ? (op_i[1] ? operand_a_i : 32'hFFFF_FFFF)
                                                 : (op_i[1] ? 32'd0 : 32'h8000_0000);
`else
    assign early_hit    = 1'b0;
    assign early_result = 32'd0;
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_reg  <= IDLE;
            count_reg  <= 5'd0;
            init_reg   <= 1'b0;
            op_reg     <= 3'd0;
            a_reg      <= 32'd0;
            b_reg      <= 32'd0;
            hi_reg     <= 32'd0;
            lo_reg     <= 32'd0;
            opnd_reg   <= 32'd0;
            result_reg <= 32'd0;
        end else if (flush_i && state_reg != IDLE) begin
            state_reg <= IDLE;
            count_reg <= 5'd0;
            init_reg  <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: if (accept) begin
                    op_reg    <= op_i;
                    a_reg     <= operand_a_i;
                    b_reg     <= operand_b_i;
                    count_reg <= 5'd0;
                    if (early_hit) begin
                        result_reg <= early_result;
                        state_reg  <= DONE;
                    end else begin
                        init_reg  <= 1'b1;
                        state_reg <= CALC;
                    end
                end
                CALC: if (init_reg) begin
                    // First CALC cycle loads operand magnitudes before iterating.
                    init_reg <= 1'b0;
                    hi_reg   <= 32'd0;
                    lo_reg   <= is_div ? a_mag : b_mag;
                    opnd_reg <= is_div ? b_mag : a_mag;
                end else begin
                    if (is_div) begin
                        hi_reg <= sub_ok ? sub_diff : shifted[31:0];
                        lo_reg <= {lo_reg[30:0], sub_ok};
                    end else begin
                        {hi_reg, lo_reg} <= {add_sum, lo_reg[31:1]};
                    end
                    count_reg <= count_reg + 5'd1;
                    if (count_reg == 5'd31) state_reg <= FIX;
                end
                FIX: begin
                    result_reg <= fix_result;
                    state_reg  <= DONE;
                end
                default: if (ready_i) state_reg <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_muldiv_seq.sv
// Randomised and directed bench for muldiv_seq against an arithmetic reference model.
`timescale 1ns/1ps
module tb_muldiv_seq;
    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        valid_i = 1'b0;
    logic        ready_o;
    logic [2:0]  op_i = 3'd0;
    logic [31:0] operand_a_i = 32'd0;
    logic [31:0] operand_b_i = 32'd0;
    logic        flush_i = 1'b0;
    logic        valid_o;
    logic        ready_i = 1'b1;
    logic [31:0] result_o;

    int checks = 0;
    int errors = 0;

    muldiv_seq dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .valid_i(valid_i), .ready_o(ready_o),
        .op_i(op_i), .operand_a_i(operand_a_i), .operand_b_i(operand_b_i),
        .flush_i(flush_i), .valid_o(valid_o), .ready_i(ready_i), .result_o(result_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [31:0] ref_result(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa;
        longint sb;
        longint ub;
        logic [63:0] p;
        bit ovf;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        ub  = longint'({32'd0, b});
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (op)
            3'd0: begin p = {32'd0, a} * {32'd0, b}; return p[31:0]; end
            3'd1: begin p = 64'(sa * sb); return p[63:32]; end
            3'd2: begin p = 64'(sa * ub); return p[63:32]; end
            3'd3: begin p = {32'd0, a} * {32'd0, b}; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (ovf) return 32'h8000_0000;
                p = 64'(sa / sb); return p[31:0];
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (ovf) return 32'd0;
                p = 64'(sa % sb); return p[31:0];
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int exp_latency(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
`ifdef RV32_MULDIV_EARLY_OUT_EN
        if (op[2] && (b == 0 || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF))) return 0;
`endif
        return 34;
    endfunction

    // Issues one request; lat counts rising edges after the accept edge until valid_o is seen.
    // If ready_i is high the result is consumed and ready/valid are sampled after that edge.
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] res, output int lat,
                         output logic rdy_after, output logic vld_after);
        @(negedge clk_i);
        valid_i = 1'b1; op_i = op; operand_a_i = a; operand_b_i = b;
        @(posedge clk_i); #1;
        valid_i = 1'b0;
        lat = 0;
        while (!valid_o && lat < 100) begin
            @(posedge clk_i); #1;
            lat++;
        end
        res = result_o;
        rdy_after = 1'b0; vld_after = 1'b1;
        if (ready_i) begin
            @(posedge clk_i); #1;
            rdy_after = ready_o; vld_after = valid_o;
        end
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        #1;
        checks++;
        if (valid_o !== 1'b0 || result_o !== 32'd0) begin
            errors++;
            $display("FAIL reset_hold valid_o=%b result_o=%h required 0/0", valid_o, result_o);
        end
        repeat (3) @(posedge clk_i);
        @(negedge clk_i); rst_ni = 1'b1;
        @(posedge clk_i); #1;
        checks++;
        if (ready_o !== 1'b1 || valid_o !== 1'b0 || result_o !== 32'd0) begin
            errors++;
            $display("FAIL reset_release ready=%b valid=%b result=%h required 1/0/0", ready_o, valid_o, result_o);
        end
        $display("reset: ready=%b valid=%b result=%h", ready_o, valid_o, result_o);
    endtask

    task automatic test_directed();
        logic [2:0]  ops [12] = '{3'd0, 3'd3, 3'd1, 3'd2, 3'd4, 3'd6, 3'd5, 3'd7, 3'd4, 3'd6, 3'd4, 3'd6};
        logic [31:0] as  [12] = '{32'd7, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFF9, 32'hFFFFFFF9,
                                  32'd100, 32'd100, 32'd5, 32'd5, 32'h80000000, 32'h80000000};
        logic [31:0] bs  [12] = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd2, 32'd2, 32'd2,
                                  32'd7, 32'd7, 32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF};
        logic [31:0] ex  [12] = '{32'hFFFFFFEB, 32'hFFFFFFFE, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFD, 32'hFFFFFFFF,
                                  32'd14, 32'd2, 32'hFFFFFFFF, 32'd5, 32'h80000000, 32'd0};
        logic [31:0] res;
        int lat;
        logic rdy, vld;
        ready_i = 1'b1;
        for (int i = 0; i < 12; i++) begin
            issue(ops[i], as[i], bs[i], res, lat, rdy, vld);
            $display("directed op=%0d a=%h b=%h result=%h latency=%0d", ops[i], as[i], bs[i], res, lat);
            checks++;
            if (res !== ex[i]) begin
                errors++;
                $display("FAIL directed_result[%0d] got %h required %h", i, res, ex[i]);
            end
            checks++;
            if (lat != exp_latency(ops[i], as[i], bs[i])) begin
                errors++;
                $display("FAIL directed_latency[%0d] got %0d required %0d", i, lat, exp_latency(ops[i], as[i], bs[i]));
            end
            checks++;
            if (rdy !== 1'b1 || vld !== 1'b0) begin
                errors++;
                $display("FAIL directed_handoff[%0d] ready=%b valid=%b required 1/0", i, rdy, vld);
            end
        end
    endtask

    task automatic test_random();
        logic [2:0]  op;
        logic [31:0] a, b, res, ex;
        int lat, sel;
        logic rdy, vld;
        ready_i = 1'b1;
        for (int i = 0; i < 40; i++) begin
            op  = 3'($urandom_range(0, 7));
            a   = $urandom;
            b   = $urandom;
            sel = $urandom_range(0, 9);
            if (sel == 0) b = 32'd0;
            else if (sel == 1) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
            else if (sel == 2) begin a = 32'($urandom_range(0, 200)); b = 32'($urandom_range(1, 20)); end
            else if (sel == 3) b = -32'($urandom_range(1, 20));
            ex = ref_result(op, a, b);
            issue(op, a, b, res, lat, rdy, vld);
            $display("random op=%0d a=%h b=%h result=%h expected=%h latency=%0d", op, a, b, res, ex, lat);
            checks++;
            if (res !== ex || lat != exp_latency(op, a, b) || rdy !== 1'b1) begin
                errors++;
                $display("FAIL random[%0d] result=%h lat=%0d ready=%b required %h/%0d/1",
                         i, res, lat, rdy, ex, exp_latency(op, a, b));
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] res;
        int lat;
        logic rdy, vld;
        ready_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            issue(3'd0, 32'(i + 2), 32'(i + 5), res, lat, rdy, vld);
            $display("back_to_back %0d*%0d result=%0d", i + 2, i + 5, res);
            checks++;
            if (res !== 32'((i + 2) * (i + 5)) || rdy !== 1'b1) begin
                errors++;
                $display("FAIL back_to_back[%0d] result=%0d ready=%b required %0d/1", i, res, rdy, (i + 2) * (i + 5));
            end
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] res;
        int lat;
        logic rdy, vld;
        ready_i = 1'b0;
        issue(3'd5, 32'd1000, 32'd9, res, lat, rdy, vld);
        checks++;
        if (res !== 32'd111) begin
            errors++;
            $display("FAIL backpressure_result got %0d required 111", res);
        end
        for (int i = 0; i < 5; i++) begin
            @(posedge clk_i); #1;
            checks++;
            if (valid_o !== 1'b1 || result_o !== res || ready_o !== 1'b0) begin
                errors++;
                $display("FAIL backpressure_hold[%0d] valid=%b result=%h ready=%b required 1/%h/0", i, valid_o, result_o, ready_o, res);
            end
        end
        ready_i = 1'b1;
        @(posedge clk_i); #1;
        checks++;
        if (valid_o !== 1'b0 || ready_o !== 1'b1) begin
            errors++;
            $display("FAIL backpressure_consume valid=%b ready=%b required 0/1", valid_o, ready_o);
        end
        $display("backpressure: result=%0d held 5 cycles then consumed", res);
    endtask

    task automatic test_flush();
        int seen;
        @(negedge clk_i);
        valid_i = 1'b1; op_i = 3'd0; operand_a_i = 32'd9; operand_b_i = 32'd9;
        @(posedge clk_i); #1;
        valid_i = 1'b0;
        // Eleven edges after accept: one load cycle plus ten iterations.
        repeat (11) @(posedge clk_i);
        #1; flush_i = 1'b1;
        @(posedge clk_i); #1;
        flush_i = 1'b0;
        checks++;
        if (ready_o !== 1'b1 || valid_o !== 1'b0) begin
            errors++;
            $display("FAIL flush_calc ready=%b valid=%b required 1/0", ready_o, valid_o);
        end
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk_i); #1;
            if (valid_o) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL flush_no_result valid cycles=%0d required 0", seen);
        end
        $display("flush in CALC: ready=%b valid cycles after=%0d", ready_o, seen);
        @(negedge clk_i);
        valid_i = 1'b1; flush_i = 1'b1; op_i = 3'd4; operand_a_i = 32'd1; operand_b_i = 32'd0;
        @(posedge clk_i); #1;
        valid_i = 1'b0; flush_i = 1'b0;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (valid_o || !ready_o) seen++;
            @(posedge clk_i); #1;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL flush_idle busy/valid cycles=%0d required 0", seen);
        end
        $display("flush in IDLE: busy/valid cycles=%0d", seen);
    endtask

    task automatic test_reset_mid();
        logic [31:0] res;
        int lat, seen;
        logic rdy, vld;
        @(negedge clk_i);
        valid_i = 1'b1; op_i = 3'd1; operand_a_i = 32'h1234_5678; operand_b_i = 32'h9ABC_DEF0;
        @(posedge clk_i); #1;
        valid_i = 1'b0;
        repeat (5) @(posedge clk_i);
        #2; rst_ni = 1'b0;
        #1;
        checks++;
        if (ready_o !== 1'b1 || valid_o !== 1'b0 || result_o !== 32'd0) begin
            errors++;
            $display("FAIL reset_mid_async ready=%b valid=%b result=%h required 1/0/0", ready_o, valid_o, result_o);
        end
        @(negedge clk_i); rst_ni = 1'b1;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk_i); #1;
            if (valid_o) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL reset_mid_no_result valid cycles=%0d required 0", seen);
        end
        ready_i = 1'b1;
        issue(3'd0, 32'd3, 32'd4, res, lat, rdy, vld);
        checks++;
        if (res !== 32'd12 || lat != 34) begin
            errors++;
            $display("FAIL reset_mid_mul result=%0d lat=%0d required 12/34", res, lat);
        end
        $display("reset mid-CALC: then 3*4=%0d latency=%0d", res, lat);
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_backpressure();
        test_flush();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/muldiv_seq.md
MULDIV_SEQ -- requirements
Module: muldiv_seq

Interface
REQ-001 Parameters: none; operand width fixed at 32.
REQ-002 clk_i  input  1  clock, all state updates on rising edge.
REQ-003 rst_ni  input  1  reset; one clock, asynchronous assert, active-low.
REQ-004 valid_i  input  1  request valid.
REQ-005 ready_o  output  1  block can accept a request.
REQ-006 op_i  input  3  RV32M funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
REQ-007 operand_a_i  input  32  rs1 value (multiplicand / dividend).
REQ-008 operand_b_i  input  32  rs2 value (multiplier / divisor).
REQ-009 flush_i  input  1  abort in-flight operation.
REQ-010 valid_o  output  1  result valid.
REQ-011 ready_i  input  1  consumer accepts result.
REQ-012 result_o  output  32  result; 0 whenever valid_o=0.

Function
REQ-013 FSM states: IDLE, CALC, FIX, DONE.
- IDLE -> CALC on accept.
- CALC -> FIX after 32 iterations.
- FIX -> DONE after 1 cycle.
- DONE -> IDLE on valid_o&&ready_i.
REQ-014 ready_o = 1 only in IDLE; accept = valid_i&&ready_o; operands and op latched at accept edge.
REQ-015 CALC: 5-bit counter 0..31, one bit per cycle.
- Multiply: radix-2 shift-add on magnitudes, 64-bit product.
- Divide: restoring shift-subtract on magnitudes, 32-bit quotient and remainder.
REQ-016 Signedness of operands:
- MULH: both signed.
- MULHSU: a signed, b unsigned.
- MULHU, DIVU, REMU: both unsigned.
- MUL: sign-agnostic.
- DIV, REM: both signed.
REQ-017 FIX applies sign correction:
- Product negated if operand signs differ (signed cases).
- Quotient negated if dividend/divisor signs differ.
- Remainder takes the dividend's sign.
REQ-018 Result selection:
- MUL: product[31:0].
- MULH, MULHSU, MULHU: product[63:32].
- DIV, DIVU: quotient.
- REM, REMU: remainder.
REQ-019 Divide by zero: quotient = 32'hFFFFFFFF; remainder = dividend (all four divide ops).
REQ-020 Signed overflow (DIV/REM, a=32'h80000000, b=32'hFFFFFFFF): quotient = 32'h80000000, remainder = 0.
REQ-021 Latency (full path): valid_o first high in the cycle after the 34th rising edge following the accept edge.
REQ-022 DONE holds valid_o and result_o stable until ready_i; ready_o = 0 throughout DONE (no accept in the handoff cycle).
REQ-023 flush_i in CALC, FIX or DONE returns the FSM to IDLE next edge; no valid_o is produced for the aborted operation.
REQ-024 flush_i in IDLE: the accept is suppressed (flush has priority over valid_i).

Reset
REQ-025 rst_ni low:
- FSM = IDLE; counter and datapath registers cleared.
- Outputs: ready_o=1 (after the reset release edge), valid_o=0, result_o=0.
REQ-026 Reset asserted mid-operation discards the operation immediately (asynchronously); no result is produced after release.

Configuration
REQ-027 Macro RV32_MULDIV_EARLY_OUT_EN.
- Defined: DIV/DIVU/REM/REMU with divisor 0, and the REQ-020 overflow case, go IDLE -> DONE directly; valid_o high one cycle after the accept edge, with REQ-019/REQ-020 values.
- Not defined: all operations take the full REQ-021 latency with identical results.

Verification
REQ-028 MUL a=7, b=-3 (32'hFFFFFFFD), ready_i=1 -> result 32'hFFFFFFEB after the REQ-021 latency; ready_o high again the next cycle.
REQ-029 MULHU a=b=32'hFFFFFFFF -> 32'hFFFFFFFE; MULH with the same operands -> 0; MULHSU a=-1, b=2 -> 32'hFFFFFFFF.
REQ-030 DIV a=-7, b=2 -> 32'hFFFFFFFD; REM with the same operands -> 32'hFFFFFFFF; DIVU a=100, b=7 -> 14; REMU -> 2.
REQ-031 DIV b=0, a=5 -> 32'hFFFFFFFF, REM -> 5; DIV 32'h80000000 / -1 -> 32'h80000000.
- Check latency with and without RV32_MULDIV_EARLY_OUT_EN (1 cycle vs full).
REQ-032 Backpressure: hold ready_i=0 for 5 cycles in DONE -> valid_o and result_o stable, ready_o=0; the result is consumed on the first ready_i=1 cycle.
REQ-033 Aborts:
- flush_i at CALC counter=10 -> IDLE next cycle, no valid_o.
- rst_ni low mid-CALC -> outputs reset immediately; a new MUL 3*4 after release -> 12.
